// File: rtl/regfile_operand_pkg.sv
// Shared constants and operand-B select encodings for the regfile_operand block.
package regfile_operand_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        BSEL_RS2 = 1'b0,
        BSEL_IMM = 1'b1
    } bsel_e;

endpackage

// File: rtl/regfile_core.sv
// Register storage x1..x(NREGS-1): synchronous clear, one write port, two raw read ports.
module regfile_core
    import regfile_operand_pkg::*;
#(
    parameter int P_XLEN   = XLEN,
    parameter int P_NREGS  = NREGS,
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_we,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    input  logic [P_XLEN-1:0]   i_rd_data,
    input  logic [P_ADDR_W-1:0] i_rs1_addr,
    input  logic [P_ADDR_W-1:0] i_rs2_addr,
    output logic [P_XLEN-1:0]   o_rs1_raw,
    output logic [P_XLEN-1:0]   o_rs2_raw
);

    // x0 has no storage; its raw read value is meaningless and gated off upstream.
    logic [P_XLEN-1:0] r_regs [1:P_NREGS-1];

    // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 1; i < P_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_rd_we && (i_rd_addr != '0)) begin
            r_regs[i_rd_addr] <= i_rd_data;
        end
    end

    assign o_rs1_raw = r_regs[i_rs1_addr];
    assign o_rs2_raw = r_regs[i_rs2_addr];

endmodule

// File: rtl/regfile_operand.sv
// Register file plus ALU operand select: x0 gating, B mux, and write-to-read
// forwarding when REGFILE_BYPASS_EN is defined.
module regfile_operand
    import regfile_operand_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rd_data,
    input  logic              i_rd_we,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_b_sel,
    output logic [XLEN-1:0]   o_a,
    output logic [XLEN-1:0]   o_b,
    output logic [XLEN-1:0]   o_rs2_data
);

    logic [XLEN-1:0] w_rs1_raw;
    logic [XLEN-1:0] w_rs2_raw;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    regfile_core #(
        .P_XLEN  (XLEN),
        .P_NREGS (NREGS),
        .P_ADDR_W(ADDR_W)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rd_we   (i_rd_we),
        .i_rd_addr (i_rd_addr),
        .i_rd_data (i_rd_data),
        .i_rs1_addr(i_rs1_addr),
        .i_rs2_addr(i_rs2_addr),
        .o_rs1_raw (w_rs1_raw),
        .o_rs2_raw (w_rs2_raw)
    );

`ifdef REGFILE_BYPASS_EN
    // Forwarding only for a write that will actually commit at the next edge.
    logic w_wr_live;
    assign w_wr_live = i_rst_n && i_rd_we && (i_rd_addr != REG_ZERO);

    assign w_rs1_data = (i_rs1_addr == REG_ZERO)                 ? '0        :
                        (w_wr_live && (i_rd_addr == i_rs1_addr)) ? i_rd_data :
                                                                   w_rs1_raw;
    assign w_rs2_data = (i_rs2_addr == REG_ZERO)                 ? '0        :
                        (w_wr_live && (i_rd_addr == i_rs2_addr)) ? i_rd_data :
                                                                   w_rs2_raw;
`else
    assign w_rs1_data = (i_rs1_addr == REG_ZERO) ? '0 : w_rs1_raw;
    assign w_rs2_data = (i_rs2_addr == REG_ZERO) ? '0 : w_rs2_raw;
`endif

    assign o_a        = w_rs1_data;
    assign o_rs2_data = w_rs2_data;
    assign o_b        = (bsel_e'(i_b_sel) == BSEL_IMM) ? i_imm : w_rs2_data;

endmodule

// File: tb/tb_regfile_operand.sv
// Self-checking bench for regfile_operand: directed vector table then random traffic
// against an array-based reference model; REGFILE_BYPASS_EN selects forwarding expectations.
module tb_regfile_operand;

    localparam int XLEN = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        bsel;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_rs2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rd_data, imm;
    logic        rd_we, b_sel;
    logic [31:0] a, b, rs2_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_operand dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rs1_addr(rs1_addr),
        .i_rs2_addr(rs2_addr),
        .i_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .i_rd_we   (rd_we),
        .i_imm     (imm),
        .i_b_sel   (b_sel),
        .o_a       (a),
        .o_b       (b),
        .o_rs2_data(rs2_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural read: stored value, or the in-flight write when forwarding applies.
    function automatic logic [31:0] ref_read(input logic [4:0] addr, input vec_t v);
        if (addr == 5'd0) return 32'h0;
        if (BYP && v.rst_n && v.we && v.rd == addr) return v.rd_data;
        return model[addr];
    endfunction

    // Apply one cycle: drive, check mid-cycle, take the edge, update the model.
    task automatic run_vec(input vec_t v, input string name);
        rst_n    = v.rst_n;
        rd_we    = v.we;
        rd_addr  = v.rd;
        rd_data  = v.rd_data;
        rs1_addr = v.rs1;
        rs2_addr = v.rs2;
        imm      = v.imm;
        b_sel    = v.bsel;
        @(negedge clk);
        check({name, ".a"}, a, v.exp_a);
        check({name, ".b"}, b, v.exp_b);
        check({name, ".rs2"}, rs2_data, v.exp_rs2);
        @(posedge clk);
        if (!v.rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (v.we && v.rd != 5'd0) begin
            model[v.rd] = v.rd_data;
        end
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [4:0] rd,
                                input logic [31:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, input logic bs, input logic [31:0] ea,
                                input logic [31:0] eb, input logic [31:0] er);
        vec_t v;
        v.rst_n = r; v.we = w; v.rd = rd; v.rd_data = d; v.rs1 = s1; v.rs2 = s2;
        v.imm = im; v.bsel = bs; v.exp_a = ea; v.exp_b = eb; v.exp_rs2 = er;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        rst_n = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0; imm = '0; b_sel = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        //          rst we rd  rd_data       rs1 rs2 imm          bs  exp_a                       exp_b                       exp_rs2
        tbl.push_back(mk(0, 0, 0, 32'h0,       0, 0, 32'h1234,    1, 32'h0,                      32'h1234,                   32'h0));
        tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF,5, 0, 32'h0,       0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0,                      32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       5, 5, 32'h0,       0, 32'hDEADBEEF,               32'hDEADBEEF,               32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 5, 32'h1,       5, 0, 32'h0,       0, 32'hDEADBEEF,               32'h0,                      32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       5, 5, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 1, 0, 32'hFFFFFFFF,0, 0, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h4,       0, 0, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 1, 2, 32'hFFFFFFFE,1, 2, 32'h0,       0, 32'h4,                      BYP ? 32'hFFFFFFFE : 32'h0, BYP ? 32'hFFFFFFFE : 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       1, 2, 32'h0,       0, 32'h4,                      32'hFFFFFFFE,               32'hFFFFFFFE));
        tbl.push_back(mk(1, 1, 3, 32'h32,      0, 0, 32'h64,      1, 32'h0,                      32'h64,                     32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       3, 3, 32'h64,      1, 32'h32,                     32'h64,                     32'h32));
        tbl.push_back(mk(1, 1, 7, 32'h1,       0, 0, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 1, 7, 32'h80000000,7, 0, 32'h0,       0, BYP ? 32'h80000000 : 32'h1, 32'h0,                      32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       7, 7, 32'h0,       0, 32'h80000000,               32'h80000000,               32'h80000000));
        tbl.push_back(mk(1, 1, 9, 32'h12345678,0, 0, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(0, 1, 9, 32'h55555555,9, 9, 32'h0,       0, 32'h12345678,               32'h12345678,               32'h12345678));
        tbl.push_back(mk(1, 0, 0, 32'h0,       9, 1, 32'h0,       0, 32'h0,                      32'h0,                      32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,       31,3, 32'hABCD,    1, 32'h0,                      32'hABCD,                   32'h0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Edge-of-array register, then both ports on it.
        run_vec(mk(1, 1, 31, 32'hA5A5_0F0F, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0), "x31_wr");
        run_vec(mk(1, 0, 0, 32'h0, 31, 31, 32'h0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F), "x31_rd");

        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v.rst_n   = ($urandom_range(0, 39) != 0);
            v.we      = ($urandom_range(0, 3) != 0);
            v.rd      = 5'($urandom_range(0, 31));
            v.rd_data = $urandom;
            v.rs1     = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
            v.rs2     = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
            v.imm     = $urandom;
            v.bsel    = 1'($urandom_range(0, 1));
            v.exp_a   = ref_read(v.rs1, v);
            v.exp_rs2 = ref_read(v.rs2, v);
            v.exp_b   = v.bsel ? v.imm : v.exp_rs2;
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_operand.md
Name: regfile_operand

Overview:
- Integer register file plus ALU operand-select stage of the single-cycle processor.
- Sits directly upstream of the ALU and drives its A and B operands.
- Two asynchronous read ports and one clocked write port (writeback). x0 is hardwired to zero.
- B is either rs2 data or the decoded immediate. rs2 data is also exported for stores.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREGS, 32, number of architectural registers (x0..x31).
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NREGS.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- RS1_ADDR  input  ADDR_W  source register 1 index.
- RS2_ADDR  input  ADDR_W  source register 2 index.
- RD_ADDR  input  ADDR_W  destination register index for writeback.
- RD_DATA  input  XLEN  writeback data (ALU RESULT or load data).
- RD_WE  input  1  writeback enable.
- IMM  input  XLEN  sign-extended immediate from decode.
- B_SEL  input  1  0: B = rs2 data; 1: B = IMM.
- A  output  XLEN  ALU operand A = rs1 data.
- B  output  XLEN  ALU operand B.
- RS2_DATA  output  XLEN  raw rs2 data for store path.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST_N; only the CLK edge acts on it.
- Storage: registers x1..x(NREGS-1), XLEN bits each. x0 has no storage and always reads 0.
- Reset: on a rising CLK edge with RST_N=0, x1..x31 clear to 0 in that same edge.
  - RD_WE is ignored on a reset edge; reset wins over a simultaneous write.
  - Once the reset edge is taken, outputs read A=0, RS2_DATA=0, and B=0 (B_SEL=0) or IMM (B_SEL=1).
  - Before the first reset edge, stored contents are undefined.
  - Reset asserted mid-program clears all registers at the next edge with no partial writes.
- Write: on a rising CLK edge with RST_N=1, RD_WE=1 and RD_ADDR!=0, reg[RD_ADDR] <= RD_DATA.
  - Writes to x0 are discarded.
  - Exactly one write per cycle.
- Read: purely combinational, zero-cycle latency from RS*_ADDR to A/RS2_DATA/B.
  - A = (RS1_ADDR==0) ? 0 : reg[RS1_ADDR].
  - RS2_DATA is formed the same way from RS2_ADDR.
  - B = B_SEL ? IMM : RS2_DATA.
- Read-after-write, same cycle, without the bypass feature:
  - Reads return the old value until the write edge.
  - After the edge, the new value appears combinationally.
- Both read ports may address the same register. A and RS2_DATA are then identical.
- No arithmetic; widths are passed through unchanged. IMM is already XLEN wide; no extension is done here.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: write-to-read forwarding.
  - If RD_WE=1, RST_N=1, RD_ADDR!=0 and RD_ADDR==RS1_ADDR, then A=RD_DATA in the same cycle.
  - The same rule applies to RS2_DATA, and therefore to B when B_SEL=0.
  - x0 is never forwarded.
  - No forwarding while RST_N=0.
- When undefined: reads return stored contents only (behaviour above).

Decomposition:
- Shared package: XLEN and NREGS constants, REG_ZERO index constant, and the B_SEL encodings (BSEL_RS2=0, BSEL_IMM=1).
- One natural sub-module: regfile_core, holding storage, reset and write, with two raw read ports.
- The top adds the x0 zero-gating, the optional bypass, and the B mux.

Test Plan:
1. Reset clears all registers:
   - Write 0xDEADBEEF to x5, then hold RST_N=0 for one edge.
   - RS1_ADDR=5 must give A=0x00000000.
2. x0 is hardwired zero:
   - Write RD_ADDR=0, RD_DATA=0xFFFFFFFF.
   - RS1_ADDR=0 must give A=0; B_SEL=0 with RS2_ADDR=0 must give B=0.
3. Basic write/read on both ports:
   - Write x1=0x00000004, then x2=0xFFFFFFFE.
   - RS1=1, RS2=2, B_SEL=0 must give A=0x4, B=0xFFFFFFFE, RS2_DATA=0xFFFFFFFE.
4. Immediate select:
   - x3=0x32, RS1=3, RS2=3, IMM=0x64, B_SEL=1.
   - Must give A=0x32, B=0x64, RS2_DATA=0x32.
5. Same-cycle read-after-write:
   - x7=0x1, then drive RD_ADDR=7, RD_DATA=0x80000000, RD_WE=1 with RS1=7.
   - Before the edge, A=0x1 without the macro and A=0x80000000 with REGFILE_BYPASS_EN.
   - After the edge, A=0x80000000 in both builds.
6. Reset beats write:
   - RST_N=0 with RD_WE=1, RD_ADDR=9, RD_DATA=0x55555555 on the same edge.
   - Next cycle, RS1=9 must give A=0 in both builds.
